// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU operand-select sequencer: instruction classes,
// operand mux selects and FSM state encoding.
package alu_ctrl_pkg;

    localparam logic [2:0] CLS_R      = 3'd0;
    localparam logic [2:0] CLS_I      = 3'd1;
    localparam logic [2:0] CLS_LUI    = 3'd2;
    localparam logic [2:0] CLS_AUIPC  = 3'd3;
    localparam logic [2:0] CLS_BRANCH = 3'd4;
    localparam logic [2:0] CLS_JAL    = 3'd5;
    localparam logic [2:0] CLS_JALR   = 3'd6;
    localparam logic [2:0] CLS_ILL    = 3'd7;

    localparam logic [1:0] OPA_RS1  = 2'b00;
    localparam logic [1:0] OPA_PC   = 2'b01;
    localparam logic [1:0] OPA_ZERO = 2'b10;

    localparam logic [1:0] OPB_RS2  = 2'b00;
    localparam logic [1:0] OPB_4    = 2'b01;
    localparam logic [1:0] OPB_IMM  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EX1  = 2'd1,
        EX2  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Classes that need a second ALU pass for the branch/jump target.
    function automatic logic is_two_pass(input logic [2:0] cls);
        return (cls == CLS_BRANCH) || (cls == CLS_JAL) || (cls == CLS_JALR);
    endfunction

endpackage

// File: rtl/opsel_decode.sv
// Operand-mux select decode from registered {state, class}; selects stay
// 00/00 with no subtract outside the two execute passes.
module opsel_decode
    import alu_ctrl_pkg::*;
(
    input  state_t      i_state,
    input  logic [2:0]  i_cls,
    output logic [1:0]  o_opa_sel,
    output logic [1:0]  o_opb_sel,
    output logic        o_alu_sub
);

    always_comb begin
        o_opa_sel = OPA_RS1;
        o_opb_sel = OPB_RS2;
        o_alu_sub = 1'b0;
        if (i_state == EX1) begin
            case (i_cls)
                CLS_I: begin
                    o_opb_sel = OPB_IMM;
                end
                CLS_LUI: begin
                    o_opa_sel = OPA_ZERO;
                    o_opb_sel = OPB_IMM;
                end
                CLS_AUIPC: begin
                    o_opa_sel = OPA_PC;
                    o_opb_sel = OPB_IMM;
                end
                CLS_BRANCH: begin
                    o_alu_sub = 1'b1;
                end
                CLS_JAL, CLS_JALR: begin
                    o_opa_sel = OPA_PC;
                    o_opb_sel = OPB_4;
                end
                default: begin
                end
            endcase
        end else if (i_state == EX2) begin
            // Second pass computes the target.
            case (i_cls)
                CLS_BRANCH, CLS_JAL: begin
                    o_opa_sel = OPA_PC;
                    o_opb_sel = OPB_IMM;
                end
                CLS_JALR: begin
                    o_opa_sel = OPA_RS1;
                    o_opb_sel = OPB_IMM;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_opsel_sequencer.sv
// Execute-stage controller: sequences the shared ALU over one or two passes
// per instruction class and holds the captured results until accepted.
module alu_opsel_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_cls,
    input  logic [XLEN-1:0] alu_res,
    output logic [1:0]      opa_sel,
    output logic [1:0]      opb_sel,
    output logic            alu_sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_res0,
    output logic [XLEN-1:0] out_res1,
    output logic            out_two,
    output logic            out_illegal
);

    state_t            r_state;
    logic [2:0]        r_cls;
    logic [XLEN-1:0]   r_res0;
    logic [XLEN-1:0]   r_res1;
    logic              r_two;
    logic              r_illegal;

    logic [1:0]        w_opa_sel;
    logic [1:0]        w_opb_sel;
    logic              w_alu_sub;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cls     <= CLS_R;
            r_res0    <= '0;
            r_res1    <= '0;
            r_two     <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_cls     <= in_cls;
                        r_illegal <= (in_cls == CLS_ILL);
                        r_res1    <= '0;
                        r_two     <= 1'b0;
                        r_state   <= EX1;
                    end
                end
                EX1: begin
                    r_res0  <= alu_res;
                    r_state <= is_two_pass(r_cls) ? EX2 : DONE;
                end
                EX2: begin
                    // JALR targets are halfword-aligned by clearing bit 0.
                    r_res1  <= (r_cls == CLS_JALR) ? {alu_res[XLEN-1:1], 1'b0} : alu_res;
                    r_two   <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    opsel_decode u_opsel_decode (
        .i_state   (r_state),
        .i_cls     (r_cls),
        .o_opa_sel (w_opa_sel),
        .o_opb_sel (w_opb_sel),
        .o_alu_sub (w_alu_sub)
    );

    assign in_ready    = (r_state == IDLE) && !rst;
    assign out_valid   = (r_state == DONE) && !rst;
    assign opa_sel     = rst ? OPA_RS1 : w_opa_sel;
    assign opb_sel     = rst ? OPB_RS2 : w_opb_sel;
    assign alu_sub     = rst ? 1'b0 : w_alu_sub;
    assign out_res0    = r_res0;
    assign out_res1    = r_res1;
    assign out_two     = r_two;
    assign out_illegal = r_illegal;

endmodule
